// File: rtl/rf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wr_arbiter
//
// Owns the single register-file write port and shares it between two
// requesters:
//   A - pipeline writeback stage (wb_*), normally has priority
//   B - multi-cycle unit results (mu_*), buffered in a small FIFO
// A wait counter bounds how long a non-empty FIFO head can be blocked by A.
// Once the bound is reached, B is forced onto the port and A is stalled.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   wb_wr_en    A wants to write this cycle
//   wb_reg      A destination register (3b)
//   wb_data     A write data (16b)
//   mu_valid    B result offered
//   mu_reg      B destination register (3b)
//   mu_data     B write data (16b)
//   mu_ready    FIFO can accept (registered occupancy only)
//   stall       A not granted this cycle
//   rf_wr_en    register-file write enable
//   rf_wr_reg   register-file write address
//   rf_wr_data  register-file write data
//   err         X/Z detected on a control input or on an enabled payload
// ---------------------------------------------------------------------------
module rf_wr_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_wr_en,
  input  logic [2:0]  wb_reg,
  input  logic [15:0] wb_data,
  input  logic        mu_valid,
  input  logic [2:0]  mu_reg,
  input  logic [15:0] mu_data,
  output logic        mu_ready,
  output logic        stall,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_reg,
  output logic [15:0] rf_wr_data,
  output logic        err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [WW-1:0] MAX_WAIT_C = WW'(MAX_WAIT);

  logic [2:0]    reg_mem  [DEPTH];
  logic [15:0]   data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_cnt;

  logic nonempty;
  logic force_b;
  logic grant_b;
  logic enq;
  logic deq;

  assign nonempty = (count != '0);
  assign force_b  = nonempty & (wait_cnt == MAX_WAIT_C);
  assign grant_b  = nonempty & (~wb_wr_en | force_b);

  // mu_ready comes from the registered count only, so a dequeue this cycle
  // does not open a slot until the next cycle.
  assign mu_ready = (count != DEPTH_C);
  assign enq      = mu_valid & mu_ready;
  assign deq      = grant_b;

  always_comb begin
    rf_wr_en   = wb_wr_en;
    rf_wr_reg  = wb_reg;
    rf_wr_data = wb_data;
    stall      = 1'b0;
    if (grant_b) begin
      rf_wr_en   = 1'b1;
      rf_wr_reg  = reg_mem[rd_ptr];
      rf_wr_data = data_mem[rd_ptr];
      stall      = wb_wr_en;
    end
  end

  // Storage is not reset: an entry is only read once count says it was
  // written, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (enq) begin
      reg_mem[wr_ptr]  <= mu_reg;
      data_mem[wr_ptr] <= mu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Counts cycles the head has been passed over by A; saturates at the bound.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (grant_b || !nonempty) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_WAIT_C) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // Payload X/Z only matters when its requester is actually asking.
  always_comb begin
    err = $isunknown(wb_wr_en) | $isunknown(mu_valid) | $isunknown(rst);
    if (wb_wr_en === 1'b1 && $isunknown({wb_reg, wb_data})) err = 1'b1;
    if (mu_valid === 1'b1 && $isunknown({mu_reg, mu_data})) err = 1'b1;
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
module tb_rf_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_wr_en;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        mu_valid;
  logic [2:0]  mu_reg;
  logic [15:0] mu_data;
  logic        mu_ready;
  logic        stall;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_reg;
  logic [15:0] rf_wr_data;
  logic        err;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0]  r;
    logic [15:0] d;
    logic        s;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  rf_wr_arbiter #(.DEPTH(2), .MAX_WAIT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_wr_en   (wb_wr_en),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .mu_valid   (mu_valid),
    .mu_reg     (mu_reg),
    .mu_data    (mu_data),
    .mu_ready   (mu_ready),
    .stall      (stall),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_reg  (rf_wr_reg),
    .rf_wr_data (rf_wr_data),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Monitor: every register-file write must match the next expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && rf_wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual reg=%0d data=%h stall=%b required none",
                 rf_wr_reg, rf_wr_data, stall);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rf_wr_reg, rf_wr_data, stall} !== {mon_e.r, mon_e.d, mon_e.s}) begin
          failures++;
          $display("FAIL rf_write actual reg=%0d data=%h stall=%b required reg=%0d data=%h stall=%b",
                   rf_wr_reg, rf_wr_data, stall, mon_e.r, mon_e.d, mon_e.s);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic set_in(input logic wb, input logic [2:0] wr, input logic [15:0] wd,
                        input logic mv, input logic [2:0] mr, input logic [15:0] md);
    wb_wr_en = wb;
    wb_reg   = wr;
    wb_data  = wd;
    mu_valid = mv;
    mu_reg   = mr;
    mu_data  = md;
  endtask

  task automatic expect_wr(input logic [2:0] r, input logic [15:0] d, input logic s);
    exp_t e;
    e.r = r;
    e.d = d;
    e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int offer [13] = '{1, 2, 3, 3, 4, 4, 5, 5, 6, 6, 0, 0, 0};
  logic probe;

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_mu_ready", mu_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_rf_wr_en", rf_wr_en, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset then idle, then one A write
    @(negedge clk);
    chk("idle_mu_ready", mu_ready, 1);
    chk("idle_stall", stall, 0);
    chk("idle_rf_wr_en", rf_wr_en, 0);
    chk("idle_err", err, 0);
    step();
    set_in(1, 5, 16'hBEEF, 0, 0, 0);
    expect_wr(5, 16'hBEEF, 0);
    @(negedge clk);
    chk("a_only_stall", stall, 0);
    chk("a_only_err", err, 0);
    step();

    // B alone: written the cycle after acceptance
    set_in(0, 0, 0, 1, 2, 16'h1234);
    @(negedge clk);
    chk("b_no_bypass", rf_wr_en, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    expect_wr(2, 16'h1234, 0);
    @(negedge clk);
    chk("b_one_mu_ready", mu_ready, 1);
    step();
    @(negedge clk);
    chk("b_drained_wr_en", rf_wr_en, 0);
    step();

    // starvation bound: 3 A writes, forced B with stall, then A again
    set_in(0, 0, 0, 1, 3, 16'h3333);
    step();
    for (int k = 1; k <= 5; k++) begin
      set_in(1, 7, 16'hA000 + 16'(k), 0, 0, 0);
      if (k == 4) expect_wr(3, 16'h3333, 1);
      else        expect_wr(7, 16'hA000 + 16'(k), 0);
      @(negedge clk);
      chk($sformatf("starve_stall_%0d", k), stall, (k == 4) ? 1 : 0);
      step();
    end
    set_in(0, 0, 0, 0, 0, 0);
    step();

    // full FIFO: third offer refused, even while the forced dequeue happens
    for (int k = 1; k <= 6; k++) begin
      case (k)
        1:       set_in(1, 6, 16'hC001, 1, 4, 16'h4444);
        2:       set_in(1, 6, 16'hC002, 1, 5, 16'h5555);
        3, 4, 5: set_in(1, 6, 16'hC000 + 16'(k), 1, 1, 16'h1111);
        default: set_in(0, 0, 0, 0, 0, 0);
      endcase
      if (k <= 4)      expect_wr(6, 16'hC000 + 16'(k), 0);
      else if (k == 5) expect_wr(4, 16'h4444, 1);
      else             expect_wr(5, 16'h5555, 0);
      @(negedge clk);
      chk($sformatf("full_mu_ready_%0d", k), mu_ready, (k >= 3 && k <= 5) ? 0 : 1);
      step();
    end
    @(negedge clk);
    chk("full_drained_wr_en", rf_wr_en, 0);
    step();

    // wrap and order: six B results with alternating A writes
    for (int k = 0; k <= 12; k++) begin
      set_in(k[0], 0, 16'hD000 + 16'(k), offer[k] != 0, 3'(offer[k]), 16'hB000 + 16'(offer[k]));
      if (k[0])        expect_wr(0, 16'hD000 + 16'(k), 0);
      else if (k >= 2) expect_wr(3'(k / 2), 16'hB000 + 16'(k / 2), 0);
      @(negedge clk);
      chk($sformatf("wrap_mu_ready_%0d", k), mu_ready, (!k[0] && k >= 2 && k <= 10) ? 0 : 1);
      step();
    end
    set_in(0, 0, 0, 0, 0, 0);
    step();

    // async reset with two entries pending and wait_cnt=2
    set_in(1, 7, 16'hE001, 1, 1, 16'h7777);
    expect_wr(7, 16'hE001, 0);
    step();
    set_in(1, 7, 16'hE002, 1, 2, 16'h8888);
    expect_wr(7, 16'hE002, 0);
    step();
    set_in(1, 7, 16'hE003, 0, 0, 0);
    expect_wr(7, 16'hE003, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("arst_mu_ready", mu_ready, 1);
    chk("arst_stall", stall, 0);
    chk("arst_rf_wr_en", rf_wr_en, 0);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("arst_no_write_%0d", k), rf_wr_en, 0);
      step();
    end
    set_in(1, 4, 16'h4A4A, 0, 0, 0);
    expect_wr(4, 16'h4A4A, 0);
    @(negedge clk);
    chk("arst_a_stall", stall, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0);

    // err: X/Z detection where the simulator can represent it
    mu_valid = 1'b1;
    mu_data  = 16'h0F0F;
    #1;
    chk("err_clean_offer", err, 0);
    mu_valid = 1'b0;
    probe = 1'bx;
    if ($isunknown(probe)) begin
      wb_wr_en = 1'bx;
      #1;
      chk("err_wb_wr_en_x", err, 1);
      wb_wr_en = 1'b0;
      wb_data  = 16'hxxxx;
      #1;
      chk("err_disabled_data_x", err, 0);
      wb_data  = 16'h0000;
      mu_valid = 1'b1;
      mu_data  = 16'hxxxx;
      #1;
      chk("err_mu_data_x", err, 1);
      mu_valid = 1'b0;
      mu_data  = 16'h0000;
    end else begin
      $display("note: two-state simulator, X/Z err cases skipped");
    end
    step();
    step();

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
